// File: rtl/novacore_cfg_pkg.sv
// rtl/novacore_cfg_pkg.sv - shared types, widths and CRC helper for the NovaCORE config loader
package novacore_cfg_pkg;

    localparam int BUS_W_DEF = 42;
    localparam int UID_W_DEF = 7;
    localparam int DIM_W_DEF = 2;
    localparam int CNT_W_DEF = 16;
    localparam int TMR_W     = 8;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIMSW,
        SETUP,
        HIGH,
        HOLD,
        DONE
    } state_e;

    // One message bit through a CRC-8 register, MSB-first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_i);
        logic fb;
        fb = crc[7] ^ bit_i;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/novacore_cfg_timer.sv
// rtl/novacore_cfg_timer.sv - loadable down-counter with zero flag for phase timing
module novacore_cfg_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/novacore_cfg_loader.sv
// rtl/novacore_cfg_loader.sv - fabric configuration sequencer; NOVACORE_CFG_CRC_EN adds session CRC-8 check
module novacore_cfg_loader
    import novacore_cfg_pkg::*;
#(
    parameter int BUS_W     = BUS_W_DEF,
    parameter int UID_W     = UID_W_DEF,
    parameter int DIM_W     = DIM_W_DEF,
    parameter int SETUP_CYC = 2,
    parameter int HIGH_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int SW_CYC    = 2,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [UID_W-1:0] in_uid,
    input  logic [DIM_W-1:0] in_dim,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_last,
    input  logic [7:0]       crc_exp,
    output logic             mode,
    output logic [BUS_W-1:0] c_bus,
    output logic [UID_W-1:0] c_uid,
    output logic             c_clk,
    output logic [DIM_W-1:0] c_dimension,
    output logic             c_dimswitch,
    output logic             busy,
    output logic             done,
    output logic             crc_err,
    output logic [CNT_W-1:0] frame_cnt
);

    state_e             state_q, state_d;
    logic               accept;
    logic               tmr_load, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;

    logic               in_ready_q, mode_q, c_clk_q, c_dimswitch_q, busy_q, done_q, last_q;
    logic [BUS_W-1:0]   c_bus_q;
    logic [UID_W-1:0]   c_uid_q;
    logic [DIM_W-1:0]   c_dimension_q;
    logic [CNT_W-1:0]   frame_cnt_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    state_d = (in_dim != c_dimension_q) ? DIMSW : SETUP;
                end
            end
            DIMSW: if (tmr_zero) state_d = SETUP;
            SETUP: if (tmr_zero) state_d = HIGH;
            HIGH:  if (tmr_zero) state_d = HOLD;
            HOLD:  if (tmr_zero) state_d = last_q ? DONE : LOAD;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every state change reloads the shared timer with that phase's length minus one.
    always_comb begin
        tmr_val = '0;
        case (state_d)
            DIMSW:   tmr_val = TMR_W'(SW_CYC - 1);
            SETUP:   tmr_val = TMR_W'(SETUP_CYC - 1);
            HIGH:    tmr_val = TMR_W'(HIGH_CYC - 1);
            HOLD:    tmr_val = TMR_W'(HOLD_CYC - 1);
            default: tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_d != state_q);

    novacore_cfg_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Outputs are decoded from the next state so strobes come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            mode_q        <= 1'b0;
            c_clk_q       <= 1'b0;
            c_dimswitch_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            last_q        <= 1'b0;
            c_bus_q       <= '0;
            c_uid_q       <= '0;
            c_dimension_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= (state_d == LOAD);
            c_clk_q       <= (state_d == HIGH);
            c_dimswitch_q <= (state_d == DIMSW);
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == DONE);
            if (state_q == IDLE && start) begin
                mode_q      <= 1'b0;
                frame_cnt_q <= '0;
            end else if (state_d == DONE) begin
                mode_q <= 1'b1;
            end
            if (accept) begin
                c_bus_q       <= in_data;
                c_uid_q       <= in_uid;
                c_dimension_q <= in_dim;
                last_q        <= in_last;
            end
            if (state_q == HOLD && tmr_zero && frame_cnt_q != '1) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

`ifdef NOVACORE_CFG_CRC_EN
    localparam int MSG_W = UID_W + DIM_W + BUS_W;

    logic [MSG_W-1:0] crc_msg;
    logic [7:0]       crc_q, crc_d;
    logic             crc_err_q;

    assign crc_msg = {in_uid, in_dim, in_data};

    always_comb begin
        crc_d = crc_q;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            crc_d = crc8_step(crc_d, crc_msg[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q     <= 8'h00;
            crc_err_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            crc_q     <= 8'h00;
            crc_err_q <= 1'b0;
        end else if (accept) begin
            crc_q <= crc_d;
            if (in_last && crc_d != crc_exp) begin
                crc_err_q <= 1'b1;
            end
        end
    end

    assign crc_err = crc_err_q;
`else
    logic unused_crc_exp;
    assign unused_crc_exp = ^crc_exp;
    assign crc_err        = 1'b0;
`endif

    assign in_ready    = in_ready_q;
    assign mode        = mode_q;
    assign c_bus       = c_bus_q;
    assign c_uid       = c_uid_q;
    assign c_clk       = c_clk_q;
    assign c_dimension = c_dimension_q;
    assign c_dimswitch = c_dimswitch_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// tb/tb_novacore_cfg_loader.sv - scoreboard bench for novacore_cfg_loader (optionally NOVACORE_CFG_CRC_EN)
module tb_novacore_cfg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [6:0]  in_uid = '0;
    logic [1:0]  in_dim = '0;
    logic [41:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [7:0]  crc_exp = '0;

    logic        in_ready, mode, c_clk, c_dimswitch, busy, done, crc_err;
    logic [41:0] c_bus;
    logic [6:0]  c_uid;
    logic [1:0]  c_dimension;
    logic [15:0] frame_cnt;

    logic        s_in_ready, s_mode, s_c_clk, s_c_dimswitch, s_busy, s_done, s_crc_err;
    logic [41:0] s_c_bus;
    logic [6:0]  s_c_uid;
    logic [1:0]  s_c_dimension;
    logic [1:0]  s_frame_cnt;

    always #5 clk = ~clk;

    novacore_cfg_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_uid(in_uid), .in_dim(in_dim), .in_data(in_data), .in_last(in_last),
        .crc_exp(crc_exp), .mode(mode), .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk),
        .c_dimension(c_dimension), .c_dimswitch(c_dimswitch), .busy(busy), .done(done),
        .crc_err(crc_err), .frame_cnt(frame_cnt)
    );

    novacore_cfg_loader #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_uid(in_uid), .in_dim(in_dim), .in_data(in_data), .in_last(in_last),
        .crc_exp(crc_exp), .mode(s_mode), .c_bus(s_c_bus), .c_uid(s_c_uid), .c_clk(s_c_clk),
        .c_dimension(s_c_dimension), .c_dimswitch(s_c_dimswitch), .busy(s_busy), .done(s_done),
        .crc_err(s_crc_err), .frame_cnt(s_frame_cnt)
    );

    typedef struct {
        logic [6:0]  uid;
        logic [1:0]  dim;
        logic [41:0] data;
        int          period;
    } frame_t;

    typedef struct {
        int   cnt;
        int   cnt_sat;
        logic crc_err;
    } sess_t;

    frame_t     frame_q[$];
    logic [1:0] dimsw_q[$];
    sess_t      sess_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC: augmented long division by x^8+x^2+x+1.
    logic [7:0] ref_rem;
    logic [1:0] cur_dim;
    int         sess_frames;

    task automatic ref_feed(input logic b);
        logic [8:0] r;
        r = {ref_rem, b};
        if (r[8]) r = r ^ 9'h107;
        ref_rem = r[7:0];
    endtask

    function automatic logic [7:0] ref_crc();
        logic [7:0] rem;
        logic [8:0] r;
        rem = ref_rem;
        for (int i = 0; i < 8; i++) begin
            r = {rem, 1'b0};
            if (r[8]) r = r ^ 9'h107;
            rem = r[7:0];
        end
        return rem;
    endfunction

    // Monitor: pops expectations when the DUT presents strobes and done.
    int cyc = 0, last_rise = 0, hi_len = 0, sw_len = 0;
    logic prev_clk = 1'b0, prev_sw = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_clk = 1'b0; prev_sw = 1'b0; prev_done = 1'b0;
            hi_len = 0; sw_len = 0;
        end else begin
            if (c_clk && !prev_clk) begin
                if (frame_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    frame_t f;
                    f = frame_q.pop_front();
                    check("c_bus", c_bus, f.data);
                    check("c_uid", c_uid, f.uid);
                    check("c_dimension", c_dimension, f.dim);
                    if (f.period > 0) check("frame_period", cyc - last_rise, f.period);
                end
                last_rise = cyc;
                hi_len = 1;
            end else if (c_clk) begin
                hi_len++;
            end
            if (!c_clk && prev_clk) check("c_clk_high_len", hi_len, 2);

            if (c_dimswitch && !prev_sw) begin
                if (dimsw_q.size() == 0) check("unexpected_dimswitch", 1, 0);
                else check("dimswitch_dim", c_dimension, dimsw_q.pop_front());
                sw_len = 1;
            end else if (c_dimswitch) begin
                sw_len++;
            end
            if (!c_dimswitch && prev_sw) check("dimswitch_len", sw_len, 2);

            if (prev_done) check("done_width", done, 0);
            if (done && !prev_done) begin
                if (sess_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    sess_t s;
                    s = sess_q.pop_front();
                    check("frame_cnt", frame_cnt, s.cnt);
                    check("frame_cnt_sat", s_frame_cnt, s.cnt_sat);
                    check("mode_at_done", mode, 1);
                    check("crc_err", crc_err, s.crc_err);
                end
            end
            prev_clk  = c_clk;
            prev_sw   = c_dimswitch;
            prev_done = done;
        end
    end

    task automatic start_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ref_rem = 8'h00;
        sess_frames = 0;
        check("mode_after_start", mode, 0);
        check("crc_err_after_start", crc_err, 0);
        check("frame_cnt_after_start", frame_cnt, 0);
    endtask

    task automatic send_frame(input logic [6:0] uid, input logic [1:0] dim, input logic [41:0] data,
                              input logic last, input int period, input logic bad_crc);
        frame_t f;
        sess_t  s;
        int     t;
        f.uid = uid; f.dim = dim; f.data = data; f.period = period;
        frame_q.push_back(f);
        if (dim != cur_dim) dimsw_q.push_back(dim);
        cur_dim = dim;
        for (int i = 6; i >= 0; i--) ref_feed(uid[i]);
        for (int i = 1; i >= 0; i--) ref_feed(dim[i]);
        for (int i = 41; i >= 0; i--) ref_feed(data[i]);
        sess_frames++;
        in_uid = uid; in_dim = dim; in_data = data; in_last = last; in_valid = 1'b1;
        crc_exp = last ? (ref_crc() ^ {7'd0, bad_crc}) : 8'hA5;
        if (last) begin
            s.cnt = sess_frames;
            s.cnt_sat = (sess_frames > 3) ? 3 : sess_frames;
`ifdef NOVACORE_CFG_CRC_EN
            s.crc_err = bad_crc;
`else
            s.crc_err = 1'b0;
`endif
            sess_q.push_back(s);
        end
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        if (last) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sess_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("done_timeout", 0, 1);
        @(negedge clk);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("in_ready_after_done", in_ready, 0);
        check("mode_after_done", mode, 1);
    endtask

    initial begin
        int t;
        cur_dim = 2'd0;
        ref_rem = 8'h00;
        sess_frames = 0;
        repeat (3) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_c_clk", c_clk, 0);
        check("rst_c_bus", c_bus, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Three same-dimension frames, valid held high.
        start_session();
        send_frame(7'h11, 2'd0, 42'h123_4567_89AB, 1'b0, 0, 1'b0);
        send_frame(7'h22, 2'd0, 42'h0FE_DCBA_9876, 1'b0, 6, 1'b0);
        send_frame(7'h33, 2'd0, 42'h3FF_0000_FFFF, 1'b1, 6, 1'b0);
        wait_done();

        // Dimension change on the second frame stretches its period.
        start_session();
        send_frame(7'h01, 2'd0, 42'h000_0000_0001, 1'b0, 0, 1'b0);
        send_frame(7'h02, 2'd2, 42'h2AA_AAAA_AAAA, 1'b0, 8, 1'b0);
        send_frame(7'h7F, 2'd2, 42'h155_5555_5555, 1'b1, 6, 1'b0);
        wait_done();

        // Idle gap in LOAD with an ignored start pulse, then a bad CRC.
        start_session();
        send_frame(7'h44, 2'd2, 42'h0AB_CDEF_1234, 1'b0, 0, 1'b0);
        in_valid = 1'b0;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("gap_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            check("gap_c_clk", c_clk, 0);
            check("gap_busy", busy, 1);
            check("gap_c_bus", c_bus, 42'h0AB_CDEF_1234);
            start = (i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("gap_frame_cnt", frame_cnt, 1);
        send_frame(7'h45, 2'd2, 42'h111_2222_3333, 1'b1, 0, 1'b1);
        wait_done();

        // Five frames: 2-bit counter saturates, next start clears crc_err.
        start_session();
        send_frame(7'h50, 2'd2, 42'h000_0000_0050, 1'b0, 0, 1'b0);
        send_frame(7'h51, 2'd2, 42'h000_0000_0051, 1'b0, 6, 1'b0);
        send_frame(7'h52, 2'd2, 42'h000_0000_0052, 1'b0, 6, 1'b0);
        send_frame(7'h53, 2'd2, 42'h000_0000_0053, 1'b0, 6, 1'b0);
        send_frame(7'h54, 2'd2, 42'h000_0000_0054, 1'b1, 6, 1'b0);
        wait_done();

        // Reset while c_clk is high.
        start_session();
        send_frame(7'h60, 2'd1, 42'h3C3_C3C3_C3C3, 1'b0, 0, 1'b0);
        in_valid = 1'b0;
        t = 0;
        while (!c_clk && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reach_high", c_clk, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_c_clk", c_clk, 0);
        check("midrst_mode", mode, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        cur_dim = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("frame_q_empty", frame_q.size(), 0);
        check("dimsw_q_empty", dimsw_q.size(), 0);
        check("sess_q_empty", sess_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
